vending_machine_param: RTL and testbench

VENDING_MACHINE_PARAM -- requirements
Module: vending_machine_param

---
 rtl/vm_pkg.sv | 31 +++
 rtl/vm_change_counter.sv | 42 ++++
 rtl/vending_machine_param.sv | 149 ++++++++++++++
 tb/tb_vending_machine_param.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vm_pkg.sv
// Shared types for the vending machine: FSM states, coin codes and coin valuation.
package vm_pkg;

    localparam int unsigned COIN_VAL_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CREDIT = 2'd1,
        ST_VEND   = 2'd2,
        ST_CHANGE = 2'd3
    } vm_state_e;

    typedef enum logic [1:0] {
        COIN_NONE = 2'd0,
        COIN_1    = 2'd1,
        COIN_5    = 2'd2,
        COIN_10   = 2'd3
    } vm_coin_e;

    function automatic logic [COIN_VAL_W-1:0] coin_value(input logic [1:0] code);
        logic [COIN_VAL_W-1:0] val;
        case (vm_coin_e'(code))
            COIN_1:  val = COIN_VAL_W'(1);
            COIN_5:  val = COIN_VAL_W'(5);
            COIN_10: val = COIN_VAL_W'(10);
            default: val = '0;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/vm_change_counter.sv
// Credit register: coin add with overflow check, price subtract, change decrement.
module vm_change_counter
    import vm_pkg::*;
#(
    parameter int unsigned CREDIT_W = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          coin_i,
    input  logic                coin_allow_i,
    input  logic                sub_en_i,
    input  logic [CREDIT_W:0]   price_i,
    input  logic                dec_en_i,
    output logic [CREDIT_W-1:0] credit_o,
    output logic [CREDIT_W:0]   eff_credit_c,
    output logic                coin_acc_c,
    output logic                zero_c
);

    localparam int unsigned SUM_W = CREDIT_W + 1;

    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [SUM_W-1:0]    sum_c;

    // Carry out of the sum means the coin would exceed the register range.
    assign sum_c        = {1'b0, credit_q} + SUM_W'(coin_value(coin_i));
    assign coin_acc_c   = coin_allow_i && (coin_i != 2'd0) && !sum_c[CREDIT_W];
    assign eff_credit_c = coin_acc_c ? sum_c : {1'b0, credit_q};
    assign zero_c       = (credit_q == '0);

    always_comb begin
        credit_d = CREDIT_W'(eff_credit_c - (sub_en_i ? price_i : SUM_W'(0)) - SUM_W'(dec_en_i));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) credit_q <= '0;
        else     credit_q <= credit_d;
    end

    assign credit_o = credit_q;

endmodule

// File: rtl/vending_machine_param.sv
// Parameterised vending machine controller with unit-by-unit change return.
// Optional per-item stock tracking is enabled by defining VM_STOCK_EN.
module vending_machine_param
    import vm_pkg::*;
#(
    parameter int unsigned N_ITEMS    = 4,
    parameter int unsigned CREDIT_W   = 7,
    parameter int unsigned PRICE_BASE = 5,
    parameter int unsigned PRICE_STEP = 3,
    parameter int unsigned STOCK_INIT = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 coin,
    input  logic                       sel_valid,
    input  logic [$clog2(N_ITEMS)-1:0] sel,
    input  logic                       cancel,
    output logic                       shipping,
    output logic [$clog2(N_ITEMS)-1:0] item,
    output logic                       change,
    output logic [CREDIT_W-1:0]        credit,
    output logic                       coin_reject,
    output logic                       short,
    output logic                       sold_out,
    output logic                       busy
);

    localparam int unsigned SEL_W = $clog2(N_ITEMS);
    localparam int unsigned SUM_W = CREDIT_W + 1;

    vm_state_e          state_q, state_d;
    logic [SEL_W-1:0]   item_q, item_d;
    logic               shipping_q, change_q, coin_reject_q, short_q, sold_out_q, busy_q;
    logic               shipping_d, change_d, coin_reject_d, short_d, sold_out_d, busy_d;
    logic               coin_allow, coin_acc, sub_en, dec_en, credit_zero;
    logic               sel_ok, in_stock;
    logic [SUM_W-1:0]   eff_credit, price;
    logic [CREDIT_W-1:0] credit_q;

    assign sel_ok     = sel_valid && (32'(sel) < N_ITEMS);
    assign price      = SUM_W'(PRICE_BASE + 32'(sel) * PRICE_STEP);
    assign coin_allow = (state_q == ST_IDLE) || (state_q == ST_CREDIT);

    vm_change_counter #(.CREDIT_W(CREDIT_W)) u_counter (
        .clk          (clk),
        .rst          (rst),
        .coin_i       (coin),
        .coin_allow_i (coin_allow),
        .sub_en_i     (sub_en),
        .price_i      (price),
        .dec_en_i     (dec_en),
        .credit_o     (credit_q),
        .eff_credit_c (eff_credit),
        .coin_acc_c   (coin_acc),
        .zero_c       (credit_zero)
    );

`ifdef VM_STOCK_EN
    localparam int unsigned STOCK_W = (STOCK_INIT < 2) ? 1 : $clog2(STOCK_INIT + 1);

    logic [STOCK_W-1:0] stock_q [N_ITEMS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_ITEMS; i++) stock_q[i] <= STOCK_W'(STOCK_INIT);
        end else if (sub_en) begin
            stock_q[sel] <= stock_q[sel] - STOCK_W'(1);
        end
    end

    assign in_stock = (stock_q[sel] != '0);
`else
    assign in_stock = 1'b1;
`endif

    always_comb begin
        state_d       = state_q;
        item_d        = item_q;
        sub_en        = 1'b0;
        dec_en        = 1'b0;
        short_d       = 1'b0;
        sold_out_d    = 1'b0;
        coin_reject_d = (coin != 2'd0) && !coin_acc;

        case (state_q)
            ST_IDLE, ST_CREDIT: begin
                if (coin_acc) state_d = ST_CREDIT;
                // Cancel wins over a same-cycle selection; the accepted coin is still returned.
                if ((state_q == ST_CREDIT) && cancel) begin
                    state_d = ST_CHANGE;
                end else if (sel_ok) begin
                    if (!in_stock) begin
                        sold_out_d = 1'b1;
                    end else if (eff_credit < price) begin
                        short_d = 1'b1;
                    end else begin
                        sub_en  = 1'b1;
                        item_d  = sel;
                        state_d = ST_VEND;
                    end
                end
            end
            ST_VEND: begin
                state_d = credit_zero ? ST_IDLE : ST_CHANGE;
            end
            ST_CHANGE: begin
                dec_en  = !credit_zero;
                state_d = (credit_q <= CREDIT_W'(1)) ? ST_IDLE : ST_CHANGE;
            end
            default: state_d = ST_IDLE;
        endcase

        shipping_d = (state_d == ST_VEND);
        change_d   = (state_d == ST_CHANGE);
        busy_d     = (state_d == ST_VEND) || (state_d == ST_CHANGE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            item_q        <= '0;
            shipping_q    <= 1'b0;
            change_q      <= 1'b0;
            coin_reject_q <= 1'b0;
            short_q       <= 1'b0;
            sold_out_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            item_q        <= item_d;
            shipping_q    <= shipping_d;
            change_q      <= change_d;
            coin_reject_q <= coin_reject_d;
            short_q       <= short_d;
            sold_out_q    <= sold_out_d;
            busy_q        <= busy_d;
        end
    end

    assign shipping    = shipping_q;
    assign item        = item_q;
    assign change      = change_q;
    assign credit      = credit_q;
    assign coin_reject = coin_reject_q;
    assign short       = short_q;
    assign sold_out    = sold_out_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_vending_machine_param.sv
// Scoreboard bench for vending_machine_param: stimulus queues expected pulses, a monitor checks them.
module tb_vending_machine_param;

    localparam int K_SHIP = 0, K_SHORT = 1, K_SOLD = 2, K_REJ = 3, K_CHG = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] coin;
    logic       sel_valid;
    logic [1:0] sel;
    logic       cancel;
    logic       shipping, change, coin_reject, short, sold_out, busy;
    logic [1:0] item;
    logic [6:0] credit;

    always #5 clk = ~clk;

    vending_machine_param dut (
        .clk         (clk),
        .rst         (rst),
        .coin        (coin),
        .sel_valid   (sel_valid),
        .sel         (sel),
        .cancel      (cancel),
        .shipping    (shipping),
        .item        (item),
        .change      (change),
        .credit      (credit),
        .coin_reject (coin_reject),
        .short       (short),
        .sold_out    (sold_out),
        .busy        (busy)
    );

    typedef struct { int item; int credit; } exp_t;

    exp_t q_ship[$], q_short[$], q_sold[$], q_rej[$], q_chg[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_ev(input int kind, input int it, input int cr);
        exp_t e;
        e.item = it;
        e.credit = cr;
        case (kind)
            K_SHIP:  q_ship.push_back(e);
            K_SHORT: q_short.push_back(e);
            K_SOLD:  q_sold.push_back(e);
            K_REJ:   q_rej.push_back(e);
            default: q_chg.push_back(e);
        endcase
    endtask

    task automatic take(input int kind, output bit ok, output exp_t e);
        ok = 1'b0;
        e.item = 0;
        e.credit = -1;
        case (kind)
            K_SHIP:  if (q_ship.size()  > 0) begin e = q_ship.pop_front();  ok = 1'b1; end
            K_SHORT: if (q_short.size() > 0) begin e = q_short.pop_front(); ok = 1'b1; end
            K_SOLD:  if (q_sold.size()  > 0) begin e = q_sold.pop_front();  ok = 1'b1; end
            K_REJ:   if (q_rej.size()   > 0) begin e = q_rej.pop_front();   ok = 1'b1; end
            default: if (q_chg.size()   > 0) begin e = q_chg.pop_front();   ok = 1'b1; end
        endcase
    endtask

    task automatic observe(input string name, input int kind, input logic pulse);
        exp_t e;
        bit   ok;
        if (pulse !== 1'b1) return;
        take(kind, ok, e);
        if (!ok) begin
            chk({name, "_unexpected_pulse"}, 1, 0);
            return;
        end
        if (kind == K_SHIP) chk("ship_item", int'(item), e.item);
        if (e.credit >= 0) chk({name, "_credit"}, int'(credit), e.credit);
    endtask

    // Monitor: one comparison per presented output pulse, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            observe("ship",     K_SHIP,  shipping);
            observe("short",    K_SHORT, short);
            observe("sold_out", K_SOLD,  sold_out);
            observe("reject",   K_REJ,   coin_reject);
            observe("change",   K_CHG,   change);
        end
    end

    task automatic apply(input logic [1:0] c, input logic sv, input logic [1:0] s, input logic cn);
        coin = c; sel_valid = sv; sel = s; cancel = cn;
        @(posedge clk); #1;
        coin = 2'd0; sel_valid = 1'b0; sel = 2'd0; cancel = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic chk_quiet(input string name);
        chk({name, "_credit"}, int'(credit), 0);
        chk({name, "_busy"}, int'(busy), 0);
    endtask

    // Return 10 units of credit, then assert reset during the third change pulse.
    task automatic reset_mid_change(input string name);
        apply(2'd3, 1'b0, 2'd0, 1'b0);
        expect_ev(K_CHG, 0, 10);
        expect_ev(K_CHG, 0, 9);
        apply(2'd0, 1'b0, 2'd0, 1'b1);
        idle(2);
        #2 rst = 1'b1;
        #1;
        chk({name, "_rst_credit"}, int'(credit), 0);
        chk({name, "_rst_change"}, int'(change), 0);
        chk({name, "_rst_busy"}, int'(busy), 0);
        chk({name, "_rst_pulses"}, int'({shipping, coin_reject, short, sold_out}), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(3);
        chk_quiet({name, "_after_rst"});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not complete within time limit");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        coin = 2'd0; sel_valid = 1'b0; sel = 2'd0; cancel = 1'b0;
        #12;
        chk("reset_credit", int'(credit), 0);
        chk("reset_item", int'(item), 0);
        chk("reset_outputs", int'({shipping, change, coin_reject, short, sold_out, busy}), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Coins 5,1 then item 0 (price 5): vend, one unit of change.
        apply(2'd2, 1'b0, 2'd0, 1'b0);
        apply(2'd1, 1'b0, 2'd0, 1'b0);
        chk("s1_credit", int'(credit), 6);
        expect_ev(K_SHIP, 0, 1);
        expect_ev(K_CHG, 0, 1);
        apply(2'd0, 1'b1, 2'd0, 1'b0);
        idle(4);
        chk_quiet("s1_end");

        // Coin 10, item 3 (price 14) is short; cancel returns 10 units.
        apply(2'd3, 1'b0, 2'd0, 1'b0);
        expect_ev(K_SHORT, 0, 10);
        apply(2'd0, 1'b1, 2'd3, 1'b0);
        idle(1);
        chk("s2_credit_after_short", int'(credit), 10);
        for (int i = 10; i >= 1; i--) expect_ev(K_CHG, 0, i);
        apply(2'd0, 1'b0, 2'd0, 1'b1);
        idle(9);
        chk("s2_last_change_credit", int'(credit), 1);
        chk("s2_last_change_busy", int'(busy), 1);
        idle(1);
        chk_quiet("s2_end");

        // Fill to 120, overflow coin rejected; coin during change rejected without a break.
        repeat (12) apply(2'd3, 1'b0, 2'd0, 1'b0);
        chk("s3_credit_120", int'(credit), 120);
        expect_ev(K_REJ, 0, 120);
        apply(2'd3, 1'b0, 2'd0, 1'b0);
        chk("s3_credit_after_reject", int'(credit), 120);
        for (int i = 120; i >= 1; i--) expect_ev(K_CHG, 0, i);
        apply(2'd0, 1'b0, 2'd0, 1'b1);
        idle(5);
        expect_ev(K_REJ, 0, -1);
        apply(2'd3, 1'b0, 2'd0, 1'b0);
        idle(113);
        chk("s3_last_change_credit", int'(credit), 1);
        chk("s3_last_change_busy", int'(busy), 1);
        idle(1);
        chk_quiet("s3_end");

        // Coin and selection in the same cycle from zero credit: exact-price vend, no change.
        expect_ev(K_SHIP, 0, 0);
        apply(2'd2, 1'b1, 2'd0, 1'b0);
        idle(3);
        chk_quiet("s4_end");

        // Cancel beats a same-cycle selection.
        apply(2'd3, 1'b0, 2'd0, 1'b0);
        for (int i = 10; i >= 1; i--) expect_ev(K_CHG, 0, i);
        apply(2'd0, 1'b1, 2'd0, 1'b1);
        idle(10);
        chk_quiet("s5_end");

        reset_mid_change("s6");

`ifdef VM_STOCK_EN
        // Item 1 costs 8: three vends from 10 units, fourth is sold out.
        for (int n = 0; n < 3; n++) begin
            apply(2'd3, 1'b0, 2'd0, 1'b0);
            expect_ev(K_SHIP, 1, 2);
            expect_ev(K_CHG, 0, 2);
            expect_ev(K_CHG, 0, 1);
            apply(2'd0, 1'b1, 2'd1, 1'b0);
            idle(4);
            chk_quiet("s7_vend_end");
        end
        apply(2'd3, 1'b0, 2'd0, 1'b0);
        expect_ev(K_SOLD, 0, 10);
        apply(2'd0, 1'b1, 2'd1, 1'b0);
        idle(1);
        chk("s7_sold_out_credit", int'(credit), 10);
        apply(2'd0, 1'b0, 2'd0, 1'b1);
        for (int i = 10; i >= 1; i--) expect_ev(K_CHG, 0, i);
        idle(11);
        chk_quiet("s7_refund_end");
        reset_mid_change("s8");
        apply(2'd3, 1'b0, 2'd0, 1'b0);
        expect_ev(K_SHIP, 1, 2);
        expect_ev(K_CHG, 0, 2);
        expect_ev(K_CHG, 0, 1);
        apply(2'd0, 1'b1, 2'd1, 1'b0);
        idle(4);
        chk_quiet("s8_restocked_end");
`endif

        idle(2);
        chk("left_ship", q_ship.size(), 0);
        chk("left_short", q_short.size(), 0);
        chk("left_sold", q_sold.size(), 0);
        chk("left_reject", q_rej.size(), 0);
        chk("left_change", q_chg.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
